bp_mc_bridge_responder: RTL and testbench

Manycore-side endpoint model for the BP <--> Manycore bridge. It accepts request packets that the bridge emits toward the manycore, executes them against a local word memory, and returns manycore return packets to the bridge.
Testbenches use it to close the bridge's outbound path without instantiating a manycore array. It is the responder counterpart of the bridge's outbound initiator.

---
 rtl/bp_mc_bridge_responder_pkg.sv | 39 +++
 rtl/bp_mc_bridge_responder_if.sv | 16 +
 rtl/bsg_fifo_1r1w_small.sv | 33 +++
 rtl/bp_mc_bridge_responder.sv | 94 +++++++++
 tb/tb_bp_mc_bridge_responder.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/bp_mc_bridge_responder_pkg.sv
// bp_mc_bridge_responder_pkg: manycore packet types, responder FSM states and default sizing
package bp_mc_bridge_responder_pkg;
  localparam int mc_x_cord_width_gp = 4;
  localparam int mc_y_cord_width_gp = 4;
  localparam int mc_data_width_gp = 32;
  localparam int mc_addr_width_gp = 16;
  localparam int mc_reg_id_width_gp = 5;
  localparam int bp_mc_responder_els_gp = 256;
  localparam int bp_mc_responder_latency_gp = 2;
  localparam int bp_mc_responder_fifo_els_gp = 4;
  typedef enum logic [3:0] {
    e_remote_load, e_remote_store, e_remote_sw, e_cache_op,
    e_remote_amoswap, e_remote_amoadd, e_remote_amoxor, e_remote_amoand,
    e_remote_amoor, e_remote_amomin, e_remote_amomax, e_remote_amominu,
    e_remote_amomaxu
  } bsg_manycore_packet_op_v2_e;
  typedef enum logic [1:0] {
    e_return_credit, e_return_int_wb, e_return_float_wb, e_return_ifetch
  } bsg_manycore_return_packet_type_e;
  typedef enum logic {eInit, eRun} bp_mc_responder_state_e;
  typedef struct packed {
    logic [mc_addr_width_gp-1:0] addr;
    bsg_manycore_packet_op_v2_e op_v2;
    logic [mc_reg_id_width_gp-1:0] reg_id;
    logic [mc_data_width_gp-1:0] payload;
    logic [mc_y_cord_width_gp-1:0] src_y_cord;
    logic [mc_x_cord_width_gp-1:0] src_x_cord;
  } bsg_manycore_packet_s;
  typedef struct packed {
    bsg_manycore_return_packet_type_e pkt_type;
    logic [mc_data_width_gp-1:0] data;
    logic [mc_reg_id_width_gp-1:0] reg_id;
    logic [mc_y_cord_width_gp-1:0] y_cord;
    logic [mc_x_cord_width_gp-1:0] x_cord;
  } bsg_manycore_return_packet_s;
  function automatic int safe_clog2(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bp_mc_bridge_responder_if.sv
// bp_mc_bridge_responder_if: request/return handshake bundle between bridge and responder
interface bp_mc_bridge_responder_if;
  import bp_mc_bridge_responder_pkg::*;
  logic v_i;
  bsg_manycore_packet_s packet_i;
  logic ready_o;
  logic return_v_o;
  bsg_manycore_return_packet_s return_packet_o;
  logic return_yumi_i;
  logic init_done_o;
  logic err_o;
  modport master (output v_i, packet_i, return_yumi_i,
                  input ready_o, return_v_o, return_packet_o, init_done_o, err_o);
  modport slave (input v_i, packet_i, return_yumi_i,
                 output ready_o, return_v_o, return_packet_o, init_done_o, err_o);
endinterface

// File: rtl/bsg_fifo_1r1w_small.sv
// bsg_fifo_1r1w_small: small circular-buffer FIFO; writer must never push when full
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p = 4
)(
  input  logic clk_i,
  input  logic reset_i,
  input  logic v_i,
  input  logic [width_p-1:0] data_i,
  output logic v_o,
  output logic [width_p-1:0] data_o,
  input  logic yumi_i
);
  localparam int lg_lp = els_p > 1 ? $clog2(els_p) : 1;
  logic [width_p-1:0] mem [els_p];
  logic [lg_lp-1:0] rd, wr;
  logic [lg_lp:0] n;
  assign v_o = n != '0;
  assign data_o = mem[rd];
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd <= '0;
      wr <= '0;
      n <= '0;
    end else begin
      wr <= v_i ? (wr == lg_lp'(els_p-1) ? '0 : wr + 1'b1) : wr;
      rd <= yumi_i ? (rd == lg_lp'(els_p-1) ? '0 : rd + 1'b1) : rd;
      n <= n + {{lg_lp{1'b0}}, v_i} - {{lg_lp{1'b0}}, yumi_i};
    end
  end
  always_ff @(posedge clk_i)
    if (v_i) mem[wr] <= data_i;
endmodule

// File: rtl/bp_mc_bridge_responder.sv
// bp_mc_bridge_responder: manycore-side endpoint executing bridge requests against a local word memory
module bp_mc_bridge_responder
  import bp_mc_bridge_responder_pkg::*;
#(
  parameter int els_p = bp_mc_responder_els_gp,
  parameter int latency_p = bp_mc_responder_latency_gp,
  parameter int fifo_els_p = bp_mc_responder_fifo_els_gp
)(
  input logic clk_i,
  input logic reset_i,
  bp_mc_bridge_responder_if.slave bus
);
  localparam int lg_els_lp = $clog2(els_p);
  localparam int cnt_w_lp = safe_clog2(fifo_els_p+1);
  bp_mc_responder_state_e state, state_n;
  logic [lg_els_lp-1:0] init_idx, idx;
  logic [mc_data_width_gp-1:0] mem [els_p];
  logic [mc_data_width_gp-1:0] old, new_word, rdata;
  logic [cnt_w_lp-1:0] count;
  logic accept, oob, wr_en, bad_op, push, err;
  bsg_manycore_return_packet_type_e rtype;
  bsg_manycore_return_packet_s resp, push_pkt;
  assign bus.ready_o = state == eRun && count < cnt_w_lp'(fifo_els_p);
  assign bus.init_done_o = state == eRun;
  assign bus.err_o = err;
  assign accept = bus.v_i & bus.ready_o;
  assign idx = bus.packet_i.addr[lg_els_lp-1:0];
  assign oob = int'(bus.packet_i.addr) >= els_p;
  assign old = oob ? '0 : mem[idx];
  always_ff @(posedge clk_i) begin
    state <= reset_i ? eInit : state_n;
    init_idx <= reset_i ? '0 : init_idx + lg_els_lp'(state == eInit);
    count <= reset_i ? '0 : count + cnt_w_lp'(accept) - cnt_w_lp'(bus.return_yumi_i);
    err <= reset_i ? 1'b0 : err | (accept & (oob | bad_op));
  end
  always_comb state_n = (state == eInit && init_idx == lg_els_lp'(els_p-1)) ? eRun : state;
  always_comb begin
    new_word = old;
    wr_en = 1'b0;
    rtype = e_return_credit;
    rdata = '0;
    bad_op = 1'b0;
    case (bus.packet_i.op_v2)
      e_remote_load: begin rtype = e_return_int_wb; rdata = old; end
      e_remote_sw: begin wr_en = 1'b1; new_word = bus.packet_i.payload; end
      e_remote_store: begin
        wr_en = 1'b1;
        for (int b = 0; b < 4; b++)
          new_word[8*b +: 8] = bus.packet_i.reg_id[b] ? bus.packet_i.payload[8*b +: 8] : old[8*b +: 8];
      end
      e_remote_amoswap: begin wr_en = 1'b1; new_word = bus.packet_i.payload; rtype = e_return_int_wb; rdata = old; end
      e_remote_amoadd: begin wr_en = 1'b1; new_word = old + bus.packet_i.payload; rtype = e_return_int_wb; rdata = old; end
      e_remote_amoor: begin wr_en = 1'b1; new_word = old | bus.packet_i.payload; rtype = e_return_int_wb; rdata = old; end
      e_cache_op: ;
      default: bad_op = 1'b1;
    endcase
  end
  // init sweep and request writes share the single memory write port
  always_ff @(posedge clk_i)
    if (state == eInit) mem[init_idx] <= '0;
    else if (accept && wr_en && !oob) mem[idx] <= new_word;
  assign resp = '{pkt_type: rtype, data: rdata, reg_id: bus.packet_i.reg_id,
                  y_cord: bus.packet_i.src_y_cord, x_cord: bus.packet_i.src_x_cord};
  // the FIFO write register supplies the last stage of delay
  if (latency_p == 1) begin : g_direct
    assign push = accept;
    assign push_pkt = resp;
  end else begin : g_pipe
    logic [latency_p-2:0] v_r;
    bsg_manycore_return_packet_s p_r [latency_p-1];
    always_ff @(posedge clk_i) begin
      v_r[0] <= reset_i ? 1'b0 : accept;
      p_r[0] <= resp;
      for (int i = latency_p-2; i > 0; i--) begin
        v_r[i] <= reset_i ? 1'b0 : v_r[i-1];
        p_r[i] <= p_r[i-1];
      end
    end
    assign push = v_r[latency_p-2];
    assign push_pkt = p_r[latency_p-2];
  end
  bsg_fifo_1r1w_small #(
    .width_p($bits(bsg_manycore_return_packet_s)),
    .els_p(fifo_els_p)
  ) fifo (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .v_i(push),
    .data_i(push_pkt),
    .v_o(bus.return_v_o),
    .data_o(bus.return_packet_o),
    .yumi_i(bus.return_yumi_i)
  );
endmodule

// File: tb/tb_bp_mc_bridge_responder.sv
// tb_bp_mc_bridge_responder: directed self-checking bench for the manycore-side responder
module tb_bp_mc_bridge_responder;
  import bp_mc_bridge_responder_pkg::*;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  int checks = 0;
  int failures = 0;
  int acc;
  bp_mc_bridge_responder_if bus();
  bp_mc_bridge_responder #(.els_p(256), .latency_p(2), .fifo_els_p(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic bsg_manycore_packet_s mk(bsg_manycore_packet_op_v2_e op, logic [15:0] a,
                                              logic [31:0] pl, logic [4:0] rid);
    mk = '{addr: a, op_v2: op, reg_id: rid, payload: pl, src_y_cord: 4'd1, src_x_cord: 4'd2};
  endfunction
  function automatic bsg_manycore_return_packet_s rp(bsg_manycore_return_packet_type_e t,
                                                     logic [31:0] d, logic [4:0] rid);
    rp = '{pkt_type: t, data: d, reg_id: rid, y_cord: 4'd1, x_cord: 4'd2};
  endfunction
  task automatic issue(string tag, bsg_manycore_packet_s p);
    bus.v_i = 1'b1;
    bus.packet_i = p;
    #1;
    chk(tag, bus.ready_o, 1'b1);
    step();
    bus.v_i = 1'b0;
  endtask
  task automatic take(string tag, bsg_manycore_return_packet_s e);
    chk({tag, "_v"}, bus.return_v_o, 1'b1);
    chk(tag, bus.return_packet_o, e);
    bus.return_yumi_i = 1'b1;
    step();
    bus.return_yumi_i = 1'b0;
  endtask
  task automatic wait_init(string tag);
    int n = 0;
    while (!bus.ready_o && n < 400) begin
      step();
      n++;
    end
    chk(tag, n, 256);
    chk({tag, "_done"}, bus.init_done_o, 1'b1);
  endtask
  initial begin
    bus.v_i = 1'b0;
    bus.packet_i = '0;
    bus.return_yumi_i = 1'b0;
    step();
    step();
    chk("rst_ready", bus.ready_o, 1'b0);
    chk("rst_ret_v", bus.return_v_o, 1'b0);
    chk("rst_done", bus.init_done_o, 1'b0);
    chk("rst_err", bus.err_o, 1'b0);
    reset_i = 1'b0;
    bus.v_i = 1'b1;
    bus.packet_i = mk(e_remote_load, 16'h10, 32'h0, 5'd1);
    wait_init("init_len");
    step();
    bus.v_i = 1'b0;
    chk("ld_lat1", bus.return_v_o, 1'b0);
    step();
    take("ld_init", rp(e_return_int_wb, 32'h0, 5'd1));
    issue("sw_acc", mk(e_remote_sw, 16'h05, 32'hCAFEBABE, 5'd3));
    chk("sw_lat1", bus.return_v_o, 1'b0);
    issue("ld5_acc", mk(e_remote_load, 16'h05, 32'h0, 5'd4));
    take("sw_credit", rp(e_return_credit, 32'h0, 5'd3));
    take("ld_sw", rp(e_return_int_wb, 32'hCAFEBABE, 5'd4));
    issue("sw6", mk(e_remote_sw, 16'h06, 32'h11223344, 5'd0));
    issue("st6", mk(e_remote_store, 16'h06, 32'hAABBCCDD, 5'b00101));
    issue("ld6", mk(e_remote_load, 16'h06, 32'h0, 5'd7));
    step();
    take("sw6_ret", rp(e_return_credit, 32'h0, 5'd0));
    take("st6_ret", rp(e_return_credit, 32'h0, 5'd5));
    take("ld6_ret", rp(e_return_int_wb, 32'h11BB33DD, 5'd7));
    issue("sw7", mk(e_remote_sw, 16'h07, 32'hFFFFFFFF, 5'd0));
    issue("add7", mk(e_remote_amoadd, 16'h07, 32'h1, 5'd1));
    issue("ld7a", mk(e_remote_load, 16'h07, 32'h0, 5'd2));
    step();
    take("sw7_ret", rp(e_return_credit, 32'h0, 5'd0));
    take("add7_ret", rp(e_return_int_wb, 32'hFFFFFFFF, 5'd1));
    take("ld7a_ret", rp(e_return_int_wb, 32'h0, 5'd2));
    issue("or7", mk(e_remote_amoor, 16'h07, 32'hF0, 5'd3));
    issue("swap7", mk(e_remote_amoswap, 16'h07, 32'h7, 5'd4));
    issue("cop7", mk(e_cache_op, 16'h07, 32'h0, 5'd5));
    issue("ld7b", mk(e_remote_load, 16'h07, 32'h0, 5'd6));
    step();
    take("or7_ret", rp(e_return_int_wb, 32'h0, 5'd3));
    take("swap7_ret", rp(e_return_int_wb, 32'hF0, 5'd4));
    take("cop7_ret", rp(e_return_credit, 32'h0, 5'd5));
    take("ld7b_ret", rp(e_return_int_wb, 32'h7, 5'd6));
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.v_i = 1'b1;
      bus.packet_i = mk(e_remote_load, 16'h05, 32'h0, 5'(i));
      #1;
      if (bus.ready_o) acc++;
      step();
    end
    bus.v_i = 1'b0;
    chk("full_acc", acc, 4);
    chk("full_ready", bus.ready_o, 1'b0);
    step();
    take("full_h0", rp(e_return_int_wb, 32'hCAFEBABE, 5'd0));
    chk("yumi_ready", bus.ready_o, 1'b1);
    bus.v_i = 1'b1;
    bus.packet_i = mk(e_remote_load, 16'h05, 32'h0, 5'd10);
    #1;
    chk("both_ready", bus.ready_o, 1'b1);
    chk("full_h1", bus.return_packet_o, rp(e_return_int_wb, 32'hCAFEBABE, 5'd1));
    bus.return_yumi_i = 1'b1;
    step();
    bus.v_i = 1'b0;
    bus.return_yumi_i = 1'b0;
    chk("both_count", bus.ready_o, 1'b1);
    issue("refill", mk(e_remote_load, 16'h05, 32'h0, 5'd11));
    chk("refull_ready", bus.ready_o, 1'b0);
    take("full_h2", rp(e_return_int_wb, 32'hCAFEBABE, 5'd2));
    take("full_h3", rp(e_return_int_wb, 32'hCAFEBABE, 5'd3));
    take("full_h10", rp(e_return_int_wb, 32'hCAFEBABE, 5'd10));
    take("full_h11", rp(e_return_int_wb, 32'hCAFEBABE, 5'd11));
    chk("pre_err", bus.err_o, 1'b0);
    issue("badop", mk(e_remote_amoxor, 16'h05, 32'h0, 5'd8));
    chk("badop_err", bus.err_o, 1'b1);
    step();
    take("badop_ret", rp(e_return_credit, 32'h0, 5'd8));
    issue("fl1", mk(e_remote_load, 16'h05, 32'h0, 5'd1));
    issue("fl2", mk(e_remote_load, 16'h05, 32'h0, 5'd2));
    issue("fl3", mk(e_remote_load, 16'h05, 32'h0, 5'd3));
    reset_i = 1'b1;
    step();
    chk("mid_rst_ret_v", bus.return_v_o, 1'b0);
    chk("mid_rst_err", bus.err_o, 1'b0);
    chk("mid_rst_ready", bus.ready_o, 1'b0);
    chk("mid_rst_done", bus.init_done_o, 1'b0);
    reset_i = 1'b0;
    wait_init("reinit_len");
    chk("reinit_ret_v", bus.return_v_o, 1'b0);
    issue("ld_clr", mk(e_remote_load, 16'h05, 32'h0, 5'd4));
    step();
    take("ld_clr_ret", rp(e_return_int_wb, 32'h0, 5'd4));
    chk("oob_pre_err", bus.err_o, 1'b0);
    issue("oob", mk(e_remote_load, 16'd256, 32'h0, 5'd9));
    chk("oob_err", bus.err_o, 1'b1);
    step();
    take("oob_ret", rp(e_return_int_wb, 32'h0, 5'd9));
    step();
    step();
    step();
    chk("oob_sticky", bus.err_o, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
